// File: rtl/up_counter_if.sv
// Bundle of control inputs and status outputs of the up_counter.
// The DUT uses the slave view; the driver uses the master view.
interface up_counter_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] limit;
    logic [1:0]       mode;
    logic             start;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap_pulse;
    logic             busy;
    logic             done;

    modport master (
        output enable, load, load_value, limit, mode, start,
        input  count, tc, wrap_pulse, busy, done
    );

    modport slave (
        input  enable, load, load_value, limit, mode, start,
        output count, tc, wrap_pulse, busy, done
    );
endinterface

// File: rtl/up_counter.sv
// Up counter with wrap, saturate and one-shot modes.
// One-shot runs through a two-state IDLE/RUN FSM.
module up_counter #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    up_counter_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] M_SAT = 2'b01;
    localparam logic [1:0] M_ONE = 2'b10;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    // Next count, FSM state and pulse flags; load beats start beats step.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        if (bus.load) begin
            count_d = bus.load_value;
        end else if (bus.mode == M_ONE && bus.start) begin
            count_d = '0;
            state_d = RUN;
        end else if (bus.mode == M_ONE) begin
            if (state_q == RUN && bus.enable) begin
                if (count_q >= bus.limit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end else if (bus.mode == M_SAT) begin
            state_d = IDLE;
            if (bus.enable && count_q < bus.limit) begin
                count_d = count_q + 1'b1;
            end
        end else begin
            state_d = IDLE;
            if (bus.enable) begin
                if (count_q == bus.limit || count_q == ONES) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            state_q <= IDLE;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.tc         = (count_q == bus.limit);
    assign bus.wrap_pulse = wrap_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = done_q;
endmodule
